memory_responder: RTL and testbench
===================================

// Module: memory_responder
// PURPOSE
//  Memory-side end of the processing unit's data bus: accepts read/write requests
//  (processor dout -> req_wdata) and returns read data (resp_rdata -> processor din).
//  Holds a word-organised RAM with configurable wait states and ARM little-endian
//  byte/halfword/word access. Reports misaligned, out-of-range and reserved-size
//  accesses as errors.
// PARAMETERS
//  DEPTH_WORDS  1024  number of 32-bit words in the RAM; byte address range 0..4*DEPTH_WORDS-1
//  WAIT_STATES  2     extra cycles between request acceptance and the access (0..15)
// PORTS
//  clk         in   1   clock, rising edge
//  reset       in   1   asynchronous, active-low reset
//  req_valid   in   1   request present
//  req_ready   out  1   responder idle and can accept a request
//  req_write   in   1   1 = write, 0 = read
//  req_size    in   2   00 byte, 01 halfword, 10 word, 11 reserved
//  req_addr    in   32  byte address
//  req_wdata   in   32  write data, right-aligned (byte in [7:0], half in [15:0])
//  resp_valid  out  1   one-cycle response strobe
//  resp_error  out  1   qualifies resp_valid: access rejected
//  resp_rdata  out  32  read data, right-aligned, zero-extended
// BEHAVIOUR
//  - Reset (reset=0, async): FSM=IDLE, req_ready=1, resp_valid=0, resp_error=0,
//    resp_rdata=0, wait counter=0. RAM contents are NOT cleared.
//  - FSM IDLE -> WAIT -> ACCESS -> IDLE. req_ready=1 only in IDLE.
//  - IDLE: on an edge with req_valid&&req_ready, latch write/size/addr/wdata and
//    load the counter with WAIT_STATES. Go to WAIT; if WAIT_STATES=0, go to ACCESS.
//  - WAIT: decrement the counter each cycle. Go to ACCESS on the edge where the counter is 1.
//  - ACCESS (one cycle): on exit edge, commit the write / capture read data, set resp_valid=1
//    for the following cycle, return to IDLE. resp_valid and req_ready are both 1 in that cycle.
//    A request accepted then starts a new transaction.
//  - Latency: from accept edge to resp_valid high = WAIT_STATES+2 edges.
//  - Error when: size=11; half with addr[0]!=0; word with addr[1:0]!=0;
//    addr[31:2] >= DEPTH_WORDS. On error: no RAM write, resp_error=1, resp_rdata=0.
//  - Lane select (little-endian): byte lane = addr[1:0], half lane = addr[1].
//    Writes modify only the addressed lanes; other bytes of the word are preserved.
//  - Reads: byte -> {24'b0, lane}; half -> {16'b0, lane}; word -> full word.
//  - resp_error and resp_rdata hold their last values when resp_valid=0.
//  - req_* inputs are ignored outside IDLE. A request that is still valid is not
//    re-accepted until IDLE.
//  - Reset mid-transaction (WAIT or ACCESS before the commit edge): transaction
//    aborted; no write is committed and no resp_valid is produced.
// TESTING
//  1 WAIT_STATES=2: word write 0xDEADBEEF @0x10, then word read @0x10 -> resp_valid
//    4 edges after each accept, rdata=0xDEADBEEF, error=0.
//  2 Word 0x11223344 @0x20; byte write 0xAA @0x22; word read -> 0x11AA3344;
//    half read @0x22 -> 0x000011AA.
//  3 Half read @0x21 -> resp_error=1, rdata=0. Word write @0x1002 -> error, no write.
//    size=11 -> error.
//  4 Word read @4*DEPTH_WORDS -> error; read @4*DEPTH_WORDS-4 -> error=0.
//  5 Write 0xCAFEF00D @0x30. Assert reset low during WAIT -> resp_valid never pulses,
//    req_ready=1. Read @0x30 returns the old contents.
//  6 WAIT_STATES=0: back-to-back reads, req_valid held high -> resp_valid every 2nd
//    cycle; accept occurs in the cycle that resp_valid is high.

Source files
------------

// File: rtl/memory_responder.sv
// memory_responder: memory-side end of the processing unit's data bus.
// A word-organised RAM with a programmable number of wait states. It supports
// little-endian byte, halfword and word access. Misaligned, out-of-range and
// reserved-size accesses come back as error responses, and they never touch
// the RAM.
//
// Ports
//   clk, reset         clock (rising edge), asynchronous active-low reset
//   req_valid/ready    request handshake; ready only while idle
//   req_write          1 = write, 0 = read
//   req_size           00 byte, 01 half, 10 word, 11 reserved (error)
//   req_addr           byte address
//   req_wdata          right-aligned write data
//   resp_valid         one-cycle response strobe
//   resp_error         access rejected (qualifies resp_valid)
//   resp_rdata         right-aligned, zero-extended read data
module memory_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_error,
  output logic [31:0] resp_rdata
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS} state_t;

  typedef struct packed {
    logic        write;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  req_t        req_q;
  logic        accept;

  logic [31:0] mem [DEPTH_WORDS];
  logic [AW-1:0] idx;
  logic [29:0] widx;
  logic        bad, commit;
  logic [3:0]  be;
  logic [31:0] wlane, rword, rsh, rdata_nxt;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: if (accept) begin
        cnt_nxt   = 4'(WAIT_STATES);
        state_nxt = (WAIT_STATES == 0) ? ACCESS : WAIT;
      end
      WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) state_nxt = ACCESS;
      end
      ACCESS:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      req_q <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) req_q <= {req_write, req_size, req_addr, req_wdata};
    end
  end

  // Access decode. Everything works from the latched request, so the req_*
  // inputs are free to change once the request has been accepted.
  assign widx = req_q.addr[31:2];
  assign idx  = req_q.addr[AW+1:2];
  assign bad  = (req_q.size == 2'b11)
             || (req_q.size == 2'b01 && req_q.addr[0])
             || (req_q.size == 2'b10 && req_q.addr[1:0] != 2'b00)
             || (widx >= 30'(DEPTH_WORDS));
  assign commit = (state == ACCESS) && req_q.write && !bad;

  // Replicate the write data across the word. The byte enables then pick out
  // the lanes to update, and the other bytes of the word keep their contents.
  always_comb begin
    be    = 4'b1111;
    wlane = req_q.wdata;
    case (req_q.size)
      2'b00: begin
        be    = 4'b0001 << req_q.addr[1:0];
        wlane = {4{req_q.wdata[7:0]}};
      end
      2'b01: begin
        be    = req_q.addr[1] ? 4'b1100 : 4'b0011;
        wlane = {2{req_q.wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // The RAM is never reset, so its contents survive a reset.
  always_ff @(posedge clk) begin
    if (commit)
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[idx][8*b +: 8] <= wlane[8*b +: 8];
  end

  assign rword = mem[idx];

  always_comb begin
    rdata_nxt = rword;
    rsh       = rword >> {req_q.addr[1:0], 3'b000};
    case (req_q.size)
      2'b00:   rdata_nxt = {24'b0, rsh[7:0]};
      2'b01:   rdata_nxt = {16'b0, rsh[15:0]};
      default: rdata_nxt = rword;
    endcase
  end

  // The response registers load only at the ACCESS exit. At all other times
  // they keep their last values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      resp_valid <= 1'b0;
      resp_error <= 1'b0;
      resp_rdata <= '0;
    end else begin
      resp_valid <= (state == ACCESS);
      if (state == ACCESS) begin
        resp_error <= bad;
        resp_rdata <= (bad || req_q.write) ? 32'h0 : rdata_nxt;
      end
    end
  end

endmodule

// File: tb/tb_memory_responder.sv
// Testbench for memory_responder. It drives two instances, one with 2 wait
// states and one with none. A byte-level model gives the expected response
// and the cycle it is due for each request.
module tb_memory_responder;
  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  valid;
  logic        write;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic [1:0]  ready, rv, rerr;
  logic [31:0] rdata [2];

  memory_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(2)) u_dut (
    .clk(clk), .reset(reset), .req_valid(valid[0]), .req_ready(ready[0]),
    .req_write(write), .req_size(size), .req_addr(addr), .req_wdata(wdata),
    .resp_valid(rv[0]), .resp_error(rerr[0]), .resp_rdata(rdata[0]));

  memory_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .reset(reset), .req_valid(valid[1]), .req_ready(ready[1]),
    .req_write(write), .req_size(size), .req_addr(addr), .req_wdata(wdata),
    .resp_valid(rv[1]), .resp_error(rerr[1]), .resp_rdata(rdata[1]));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    bit          err;
    logic [31:0] rdata;
    bit          chk;
  } exp_t;

  exp_t        q [2][$];
  logic [7:0]  mm [int];
  int          checks = 0, errors = 0;
  logic [31:0] last_rdata [2];
  logic        last_err [2];
  int          last_cyc [2], last_acc [2];
  logic        last_rv_acc [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model at the byte level. The error rules and the little-endian byte order
  // come straight from the address and size.
  task automatic model(input int s, input bit w, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] d, output bit err, output logic [31:0] rd);
    err = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00)
       || (a >= 32'(4 * DEPTH));
    rd = 32'h0;
    if (!err)
      for (int i = 0; i < (1 << sz); i++) begin
        int k;
        k = s * 65536 + int'(a) + i;
        if (w) mm[k] = d[8*i +: 8];
        else   rd[8*i +: 8] = mm.exists(k) ? mm[k] : 8'hxx;
      end
  endtask

  // Compare process. On every cycle out of reset, resp_valid must match
  // whether a response is due. When one is due, the error flag and read data
  // must match the model too.
  always @(negedge clk) begin
    if (reset) begin
      for (int s = 0; s < 2; s++) begin
        while (q[s].size() > 0 && q[s][0].due < cyc) void'(q[s].pop_front());
        if (q[s].size() > 0 && q[s][0].due == cyc) begin
          exp_t e;
          e = q[s].pop_front();
          chk($sformatf("dut%0d resp_valid", s), 32'(rv[s]), 32'd1);
          chk($sformatf("dut%0d resp_error", s), 32'(rerr[s]), 32'(e.err));
          if (e.chk) chk($sformatf("dut%0d resp_rdata", s), rdata[s], e.rdata);
          last_rdata[s] = rdata[s];
          last_err[s]   = rerr[s];
          last_cyc[s]   = cyc;
        end else begin
          chk($sformatf("dut%0d resp_valid idle", s), 32'(rv[s]), 32'd0);
        end
      end
    end
  end

  // Issue a request at a negedge while ready is high. The edge that follows
  // accepts it. With keep set, req_valid stays high afterwards. With abort
  // set, no response is expected and the model is left unchanged.
  task automatic issue(input int s, input bit w, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] d, input bit keep, input bit abort);
    int n = 0;
    exp_t e;
    bit err;
    logic [31:0] rd;
    while (!ready[s] && n < 50) begin @(negedge clk); n++; end
    if (!ready[s]) begin
      chk($sformatf("dut%0d req_ready timeout", s), 32'(ready[s]), 32'd1);
      valid[s] = 1'b0;
      return;
    end
    write = w; size = sz; addr = a; wdata = d; valid[s] = 1'b1;
    last_rv_acc[s] = rv[s];
    @(negedge clk);
    last_acc[s] = cyc;
    if (!keep) valid[s] = 1'b0;
    if (!abort) begin
      model(s, w, sz, a, d, err, rd);
      e.due   = cyc + ((s == 0) ? 2 : 0) + 1;
      e.err   = err;
      e.rdata = rd;
      e.chk   = err || !w;
      q[s].push_back(e);
    end
  endtask

  task automatic drain(input int s);
    int n = 0;
    while (q[s].size() > 0 && n < 100) begin @(negedge clk); n++; end
    chk($sformatf("dut%0d response timeout", s), 32'(q[s].size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int a1;
    valid = 2'b00; write = 1'b0; size = 2'b00; addr = '0; wdata = '0;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      chk($sformatf("dut%0d reset ready", s), 32'(ready[s]), 32'd1);
      chk($sformatf("dut%0d reset resp_valid", s), 32'(rv[s]), 32'd0);
      chk($sformatf("dut%0d reset resp_error", s), 32'(rerr[s]), 32'd0);
      chk($sformatf("dut%0d reset resp_rdata", s), rdata[s], 32'd0);
    end
    reset = 1'b1;
    @(negedge clk);

    // Test 1: word write then word read. Counting the accept edge itself, the
    // response arrives 4 edges later, which is 3 cycles after the accept.
    issue(0, 1, 2'b10, 32'h10, 32'hDEADBEEF, 0, 0); drain(0);
    chk("t1 write latency", 32'(last_cyc[0] - last_acc[0]), 32'd3);
    chk("t1 write error", 32'(last_err[0]), 32'd0);
    issue(0, 0, 2'b10, 32'h10, 32'h0, 0, 0); drain(0);
    chk("t1 read latency", 32'(last_cyc[0] - last_acc[0]), 32'd3);
    chk("t1 read data", last_rdata[0], 32'hDEADBEEF);

    // Test 2: lane merge.
    issue(0, 1, 2'b10, 32'h20, 32'h11223344, 0, 0);
    issue(0, 1, 2'b00, 32'h22, 32'h000000AA, 0, 0);
    issue(0, 0, 2'b10, 32'h20, 32'h0, 0, 0); drain(0);
    chk("t2 word after byte write", last_rdata[0], 32'h11AA3344);
    issue(0, 0, 2'b01, 32'h22, 32'h0, 0, 0); drain(0);
    chk("t2 upper half read", last_rdata[0], 32'h000011AA);
    issue(0, 0, 2'b00, 32'h23, 32'h0, 0, 0); drain(0);
    chk("t2 byte lane 3", last_rdata[0], 32'h00000011);
    issue(0, 0, 2'b01, 32'h20, 32'h0, 0, 0); drain(0);
    chk("t2 lower half read", last_rdata[0], 32'h00003344);
    issue(0, 1, 2'b01, 32'h12, 32'h0000BEEF, 0, 0);
    issue(0, 0, 2'b10, 32'h10, 32'h0, 0, 0); drain(0);
    chk("t2 half write merge", last_rdata[0], 32'hBEEFBEEF);

    // Test 3: error responses, none of which may write the RAM.
    issue(0, 0, 2'b01, 32'h21, 32'h0, 0, 0); drain(0);
    chk("t3 misaligned half error", 32'(last_err[0]), 32'd1);
    chk("t3 misaligned half data", last_rdata[0], 32'd0);
    issue(0, 1, 2'b10, 32'h1002, 32'h55555555, 0, 0); drain(0);
    chk("t3 bad word write error", 32'(last_err[0]), 32'd1);
    issue(0, 1, 2'b11, 32'h20, 32'hFFFFFFFF, 0, 0); drain(0);
    chk("t3 reserved size error", 32'(last_err[0]), 32'd1);
    @(negedge clk);
    chk("t3 error held", 32'(rerr[0]), 32'd1);
    chk("t3 rdata held", rdata[0], 32'd0);
    issue(0, 0, 2'b10, 32'h20, 32'h0, 0, 0); drain(0);
    chk("t3 no write on error", last_rdata[0], 32'h11AA3344);

    // Test 4: range boundary.
    issue(0, 1, 2'b10, 32'(4 * DEPTH - 4), 32'h5A5A0FFC, 0, 0);
    issue(0, 0, 2'b10, 32'(4 * DEPTH), 32'h0, 0, 0); drain(0);
    chk("t4 past end error", 32'(last_err[0]), 32'd1);
    issue(0, 0, 2'b10, 32'(4 * DEPTH - 4), 32'h0, 0, 0); drain(0);
    chk("t4 last word error", 32'(last_err[0]), 32'd0);
    chk("t4 last word data", last_rdata[0], 32'h5A5A0FFC);

    // Test 5: a reset during WAIT aborts the pending write.
    issue(0, 1, 2'b10, 32'h30, 32'hCAFEF00D, 0, 0); drain(0);
    issue(0, 1, 2'b10, 32'h30, 32'h12345678, 0, 1);
    reset = 1'b0;
    #1;
    chk("t5 ready in reset", 32'(ready[0]), 32'd1);
    chk("t5 resp_valid in reset", 32'(rv[0]), 32'd0);
    chk("t5 rdata in reset", rdata[0], 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    chk("t5 ready after abort", 32'(ready[0]), 32'd1);
    issue(0, 0, 2'b10, 32'h30, 32'h0, 0, 0); drain(0);
    chk("t5 old contents", last_rdata[0], 32'hCAFEF00D);

    // Test 6: zero wait states. Back-to-back reads with req_valid held high.
    issue(1, 1, 2'b10, 32'h0, 32'h01010101, 0, 0);
    issue(1, 1, 2'b10, 32'h4, 32'h02020202, 0, 0);
    issue(1, 1, 2'b10, 32'h8, 32'h03030303, 0, 0); drain(1);
    chk("t6 write latency", 32'(last_cyc[1] - last_acc[1]), 32'd1);
    issue(1, 0, 2'b10, 32'h0, 32'h0, 1, 0);
    a1 = last_acc[1];
    issue(1, 0, 2'b10, 32'h4, 32'h0, 1, 0);
    chk("t6 accept spacing 1", 32'(last_acc[1] - a1), 32'd2);
    chk("t6 accept with resp_valid 1", 32'(last_rv_acc[1]), 32'd1);
    a1 = last_acc[1];
    issue(1, 0, 2'b10, 32'h8, 32'h0, 0, 0);
    chk("t6 accept spacing 2", 32'(last_acc[1] - a1), 32'd2);
    chk("t6 accept with resp_valid 2", 32'(last_rv_acc[1]), 32'd1);
    drain(1);
    chk("t6 last read data", last_rdata[1], 32'h03030303);
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
